// File: rtl/r_peak_detector.sv
// Adaptive-threshold R-peak detector: finds local maxima above a decaying threshold,
// reports R-R spacing in samples and restarts the external refractory counter per peak.
//
// state     | meaning
// WAIT_REFR | refractory; waits for limit (ignored for one cycle after EMIT)
// SEARCH    | waits for a sample above threshold
// CONFIRM   | tracks the running maximum until SEARCH_LEN quiet samples pass
// EMIT      | one cycle: publish peak, update threshold, rebase rr_cnt
module r_peak_detector #(
  parameter int DATA_W     = 16,
  parameter int CNT_W      = 16,
  parameter int THR_INIT   = 2000,
  parameter int THR_MIN    = 64,
  parameter int SEARCH_LEN = 8,
  parameter int RR_TIMEOUT = 400
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_sample_valid,
  input  logic [DATA_W-1:0] i_sample,
  input  logic              i_limit,
  output logic              o_limit_clr,
  output logic              o_peak_valid,
  output logic [DATA_W-1:0] o_peak_amp,
  output logic              o_rr_valid,
  output logic [CNT_W-1:0]  o_rr_interval,
  output logic [DATA_W-1:0] o_threshold
);

  localparam int                 Q_W          = $clog2(SEARCH_LEN + 1);
  localparam int                 WX           = DATA_W + 3;
  localparam logic [CNT_W-1:0]   CNT_MAX      = '1;
  localparam logic [DATA_W-1:0]  THR_INIT_V   = DATA_W'(THR_INIT);
  localparam logic [DATA_W-1:0]  THR_MIN_V    = DATA_W'(THR_MIN);
  localparam logic [WX-1:0]      THR_MIN_X    = WX'(THR_MIN);
  localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(RR_TIMEOUT - 1);
  localparam logic [Q_W-1:0]     QUIET_LAST   = Q_W'(SEARCH_LEN - 1);

  typedef enum logic [1:0] {
    WAIT_REFR = 2'd0,
    SEARCH    = 2'd1,
    CONFIRM   = 2'd2,
    EMIT      = 2'd3
  } state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_rr_cnt;
  logic [CNT_W-1:0]  r_miss_cnt;
  logic [CNT_W-1:0]  r_max_idx;
  logic [DATA_W-1:0] r_max_amp;
  logic [Q_W-1:0]    r_quiet;
  logic              r_first_peak;
  logic              r_ignore_limit;
  logic [DATA_W-1:0] r_threshold;
  logic              r_limit_clr;
  logic              r_peak_valid;
  logic [DATA_W-1:0] r_peak_amp;
  logic              r_rr_valid;
  logic [CNT_W-1:0]  r_rr_interval;

  logic [CNT_W-1:0]  w_rr_inc;
  logic [CNT_W-1:0]  w_rr_after_emit;
  logic              w_miss_hit;
  logic [DATA_W-1:0] w_thr_half;
  logic [DATA_W-1:0] w_thr_halved;
  logic [WX-1:0]     w_thr_sum;
  logic [WX-1:0]     w_thr_mix;
  logic [DATA_W-1:0] w_thr_emit;

  assign w_rr_inc        = (r_rr_cnt == CNT_MAX) ? CNT_MAX : r_rr_cnt + CNT_W'(1);
  // Samples already elapsed after the peak sample, including one arriving in EMIT.
  assign w_rr_after_emit = r_rr_cnt - r_max_idx + CNT_W'(i_sample_valid);
  assign w_miss_hit      = i_sample_valid && (r_miss_cnt == TIMEOUT_LAST);

  assign w_thr_half   = r_threshold >> 1;
  assign w_thr_halved = (w_thr_half < THR_MIN_V) ? THR_MIN_V : w_thr_half;

  // 7/8 old threshold + 1/16 of the new peak; widened so 7*thr cannot overflow.
  assign w_thr_sum  = WX'(7) * {3'b000, r_threshold} + ({3'b000, r_max_amp} >> 1);
  assign w_thr_mix  = w_thr_sum >> 3;
  assign w_thr_emit = (w_thr_mix < THR_MIN_X) ? THR_MIN_V : DATA_W'(w_thr_mix);

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state        <= WAIT_REFR;
      r_rr_cnt       <= '0;
      r_miss_cnt     <= '0;
      r_max_idx      <= '0;
      r_max_amp      <= '0;
      r_quiet        <= '0;
      r_first_peak   <= 1'b1;
      r_ignore_limit <= 1'b0;
      r_threshold    <= THR_INIT_V;
      r_limit_clr    <= 1'b0;
      r_peak_valid   <= 1'b0;
      r_peak_amp     <= '0;
      r_rr_valid     <= 1'b0;
      r_rr_interval  <= '0;
    end else begin
      r_limit_clr  <= 1'b0;
      r_peak_valid <= 1'b0;
      r_rr_valid   <= 1'b0;

      if (r_state != EMIT && i_sample_valid) begin
        r_rr_cnt <= w_rr_inc;
        if (w_miss_hit) begin
          r_miss_cnt  <= '0;
          r_threshold <= w_thr_halved;
        end else begin
          r_miss_cnt <= r_miss_cnt + CNT_W'(1);
        end
      end

      case (r_state)
        WAIT_REFR: begin
          r_ignore_limit <= 1'b0;
          if (i_limit && !r_ignore_limit) r_state <= SEARCH;
        end
        SEARCH: begin
          if (i_sample_valid && (i_sample > r_threshold)) begin
            r_max_amp <= i_sample;
            r_max_idx <= w_rr_inc;
            r_quiet   <= '0;
            r_state   <= CONFIRM;
          end
        end
        CONFIRM: begin
          if (i_sample_valid) begin
            if (i_sample > r_max_amp) begin
              r_max_amp <= i_sample;
              r_max_idx <= w_rr_inc;
              r_quiet   <= '0;
            end else begin
              r_quiet <= r_quiet + Q_W'(1);
              if (r_quiet == QUIET_LAST) r_state <= EMIT;
            end
          end
        end
        EMIT: begin
          r_peak_valid <= 1'b1;
          r_peak_amp   <= r_max_amp;
          r_limit_clr  <= 1'b1;
          if (!r_first_peak) begin
            r_rr_valid    <= 1'b1;
            r_rr_interval <= r_max_idx;
          end
          r_rr_cnt       <= w_rr_after_emit;
          r_miss_cnt     <= '0;
          r_first_peak   <= 1'b0;
          r_threshold    <= w_thr_emit;
          r_ignore_limit <= 1'b1;
          r_state        <= WAIT_REFR;
        end
        default: r_state <= WAIT_REFR;
      endcase
    end
  end

  assign o_limit_clr   = r_limit_clr;
  assign o_peak_valid  = r_peak_valid;
  assign o_peak_amp    = r_peak_amp;
  assign o_rr_valid    = r_rr_valid;
  assign o_rr_interval = r_rr_interval;
  assign o_threshold   = r_threshold;

endmodule
